// File: rtl/synth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : synth_pkg
//  Description : Shared definitions for the synth voice path: piano-key scan
//                code map, voice state encoding and note width.
//  Revision    : 1.0 - initial release
// ============================================================================
package synth_pkg;

    localparam int NOTE_W = 7;
    localparam int KEY_W  = 4;

    // Set 2 scan codes of the 13 piano keys, C up to the next C
    localparam logic [7:0] c_SC_K0  = 8'h1C;
    localparam logic [7:0] c_SC_K1  = 8'h1D;
    localparam logic [7:0] c_SC_K2  = 8'h1B;
    localparam logic [7:0] c_SC_K3  = 8'h24;
    localparam logic [7:0] c_SC_K4  = 8'h23;
    localparam logic [7:0] c_SC_K5  = 8'h2B;
    localparam logic [7:0] c_SC_K6  = 8'h2C;
    localparam logic [7:0] c_SC_K7  = 8'h34;
    localparam logic [7:0] c_SC_K8  = 8'h35;
    localparam logic [7:0] c_SC_K9  = 8'h33;
    localparam logic [7:0] c_SC_K10 = 8'h3C;
    localparam logic [7:0] c_SC_K11 = 8'h3B;
    localparam logic [7:0] c_SC_K12 = 8'h42;

    typedef enum logic [1:0] {
        V_IDLE    = 2'd0,
        V_HELD    = 2'd1,
        V_RELEASE = 2'd2
    } voice_state_e;

    // Key index -> scan code; out-of-range indices map to an unused code
    function automatic logic [7:0] key_scan_code(input logic [KEY_W-1:0] idx);
        logic [7:0] code;
        case (idx)
            4'd0:    code = c_SC_K0;
            4'd1:    code = c_SC_K1;
            4'd2:    code = c_SC_K2;
            4'd3:    code = c_SC_K3;
            4'd4:    code = c_SC_K4;
            4'd5:    code = c_SC_K5;
            4'd6:    code = c_SC_K6;
            4'd7:    code = c_SC_K7;
            4'd8:    code = c_SC_K8;
            4'd9:    code = c_SC_K9;
            4'd10:   code = c_SC_K10;
            4'd11:   code = c_SC_K11;
            4'd12:   code = c_SC_K12;
            default: code = 8'h00;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/voice_select.sv
`default_nettype none
// ============================================================================
//  Module      : voice_select
//  Description : Combinational target picker for a note-on. Priority:
//                retrigger a releasing voice with the same key, else lowest
//                free voice, else oldest releasing voice, else oldest held
//                voice (age ties resolve to the lowest index).
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_select
    import synth_pkg::*;
#(
    parameter int N_VOICES = 4,
    parameter int AGE_W    = 3,
    parameter int IDX_W    = $clog2(N_VOICES)
) (
    input  logic [N_VOICES-1:0][1:0]       state_i,
    input  logic [N_VOICES-1:0][KEY_W-1:0] key_i,
    input  logic [N_VOICES-1:0][AGE_W-1:0] age_i,
    input  logic [KEY_W-1:0]               key_evt_i,
    output logic [IDX_W-1:0]               target_o,
    output logic                           retrig_o
);

    logic              w_found_rt;
    logic [IDX_W-1:0]  w_rt_idx;
    logic              w_found_idle;
    logic [IDX_W-1:0]  w_idle_idx;
    logic              w_found_rel;
    logic [IDX_W-1:0]  w_rel_idx;
    logic [AGE_W-1:0]  w_rel_age;
    logic              w_found_held;
    logic [IDX_W-1:0]  w_held_idx;
    logic [AGE_W-1:0]  w_held_age;

    // Scan all voices once, tracking the best candidate of each class;
    // strict '>' on age keeps the lowest index on ties
    always_comb begin
        w_found_rt   = 1'b0;
        w_rt_idx     = '0;
        w_found_idle = 1'b0;
        w_idle_idx   = '0;
        w_found_rel  = 1'b0;
        w_rel_idx    = '0;
        w_rel_age    = '0;
        w_found_held = 1'b0;
        w_held_idx   = '0;
        w_held_age   = '0;
        for (int v = 0; v < N_VOICES; v++) begin
            if (!w_found_rt && state_i[v] == V_RELEASE && key_i[v] == key_evt_i) begin
                w_found_rt = 1'b1;
                w_rt_idx   = IDX_W'(v);
            end
            if (!w_found_idle && state_i[v] == V_IDLE) begin
                w_found_idle = 1'b1;
                w_idle_idx   = IDX_W'(v);
            end
            if (state_i[v] == V_RELEASE && (!w_found_rel || age_i[v] > w_rel_age)) begin
                w_found_rel = 1'b1;
                w_rel_idx   = IDX_W'(v);
                w_rel_age   = age_i[v];
            end
            if (state_i[v] == V_HELD && (!w_found_held || age_i[v] > w_held_age)) begin
                w_found_held = 1'b1;
                w_held_idx   = IDX_W'(v);
                w_held_age   = age_i[v];
            end
        end
    end

    // Apply the class priority
    always_comb begin
        retrig_o = 1'b0;
        target_o = w_held_idx;
        if (w_found_rt) begin
            retrig_o = 1'b1;
            target_o = w_rt_idx;
        end else if (w_found_idle) begin
            target_o = w_idle_idx;
        end else if (w_found_rel) begin
            target_o = w_rel_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : voice_allocator
//  Description : Polyphonic voice scheduler. Scans the piano keys one per
//                clock, turns key edges into note-on/off events and maps
//                them onto a bank of voices with free-first, oldest-steal
//                allocation. Drives gate/trigger/note to each voice.
//  Revision    : 1.0 - initial release
// ============================================================================
module voice_allocator
    import synth_pkg::*;
#(
    parameter int N_VOICES = 4,
    parameter int NUM_KEYS = 13,
    parameter int AGE_W    = 3
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [255:0]                 key_down,
    input  logic [3:0]                   octave,
    input  logic [N_VOICES-1:0]          rel_done,
    input  logic                         panic,
    output logic [N_VOICES-1:0]          voice_gate,
    output logic [N_VOICES-1:0]          voice_trig,
    output logic [N_VOICES-1:0]          voice_busy,
    output logic [NOTE_W*N_VOICES-1:0]   voice_note
);

    localparam int               IDX_W      = $clog2(N_VOICES);
    localparam logic [AGE_W-1:0] c_AGE_MAX  = '1;
    localparam logic [KEY_W-1:0] c_LAST_KEY = KEY_W'(NUM_KEYS - 1);

    // Scanner state
    logic [KEY_W-1:0]    scan_q, scan_d;
    logic [NUM_KEYS-1:0] prev_q, prev_d;

    // Per-voice state
    voice_state_e [N_VOICES-1:0]    state_q, state_d;
    logic [N_VOICES-1:0][KEY_W-1:0] key_q, key_d;
    logic [N_VOICES-1:0][NOTE_W-1:0] note_q, note_d;
    logic [N_VOICES-1:0][AGE_W-1:0] age_q, age_d;
    logic [N_VOICES-1:0]            gate_q, gate_d;
    logic [N_VOICES-1:0]            trig_q, trig_d;

    logic                           w_now;
    logic                           w_note_on;
    logic                           w_note_off;
    logic [NOTE_W-1:0]              w_new_note;
    logic [N_VOICES-1:0][1:0]       w_state_bits;
    logic [IDX_W-1:0]               w_target;
    logic                           w_retrig;
    logic                           w_unused_sink;

    // Only 13 of the 256 scan-code bits matter; the retrigger flag only
    // documents why a voice was chosen, allocation handles it identically
    assign w_unused_sink = ^{key_down, w_retrig};

    // Edge detection on the key currently under the scanner
    always_comb begin
        w_now      = key_down[key_scan_code(scan_q)];
        w_note_on  = w_now & ~prev_q[scan_q];
        w_note_off = ~w_now & prev_q[scan_q];
        w_new_note = ({3'b000, octave} * 7'd12) + {3'b000, scan_q};
        prev_d         = prev_q;
        prev_d[scan_q] = w_now;
        scan_d         = (scan_q == c_LAST_KEY) ? '0 : scan_q + 4'd1;
    end

    // Flatten voice states for the selector
    always_comb begin
        w_state_bits = '0;
        for (int v = 0; v < N_VOICES; v++) begin
            w_state_bits[v] = state_q[v];
        end
    end

    voice_select #(
        .N_VOICES (N_VOICES),
        .AGE_W    (AGE_W),
        .IDX_W    (IDX_W)
    ) u_voice_select (
        .state_i   (w_state_bits),
        .key_i     (key_q),
        .age_i     (age_q),
        .key_evt_i (scan_q),
        .target_o  (w_target),
        .retrig_o  (w_retrig)
    );

    // Voice next-state: panic overrides everything, then allocation beats
    // a same-cycle release-done on the target, then aging and note-off
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        note_d  = note_q;
        age_d   = age_q;
        trig_d  = '0;
        gate_d  = '0;
        for (int v = 0; v < N_VOICES; v++) begin
            if (panic) begin
                state_d[v] = V_IDLE;
                age_d[v]   = '0;
            end else if (w_note_on && w_target == IDX_W'(v)) begin
                state_d[v] = V_HELD;
                key_d[v]   = scan_q;
                note_d[v]  = w_new_note;
                age_d[v]   = '0;
                trig_d[v]  = 1'b1;
            end else if (state_q[v] == V_RELEASE && rel_done[v]) begin
                state_d[v] = V_IDLE;
                age_d[v]   = '0;
            end else if (w_note_on && state_q[v] != V_IDLE) begin
                if (age_q[v] != c_AGE_MAX) begin
                    age_d[v] = age_q[v] + 1'b1;
                end
            end else if (w_note_off && state_q[v] == V_HELD && key_q[v] == scan_q) begin
                state_d[v] = V_RELEASE;
            end
            gate_d[v] = (state_d[v] == V_HELD);
        end
    end

    // Scanner registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_q <= '0;
            prev_q <= '0;
        end else begin
            scan_q <= scan_d;
            prev_q <= prev_d;
        end
    end

    // Voice registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= {N_VOICES{V_IDLE}};
            key_q   <= '0;
            note_q  <= '0;
            age_q   <= '0;
            gate_q  <= '0;
            trig_q  <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            note_q  <= note_d;
            age_q   <= age_d;
            gate_q  <= gate_d;
            trig_q  <= trig_d;
        end
    end

    assign voice_gate = gate_q;
    assign voice_trig = trig_q;

    generate
        for (genvar v = 0; v < N_VOICES; v++) begin : g_out
            assign voice_busy[v]                    = (state_q[v] != V_IDLE);
            assign voice_note[NOTE_W*v +: NOTE_W]   = note_q[v];
        end
    endgenerate

endmodule
`default_nettype wire
